// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with zr/ng flags and a completed-transfer counter.
// Stage 1 registers the operands; stage 2 computes and registers the result and flags.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_x_q;
    logic [WIDTH-1:0] s1_y_q;
    logic [2:0]       s1_op_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_q;
    logic             zr_q;
    logic             ng_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             s2_ready;
    logic             s1_load;
    logic             s1_advance;
    logic [WIDTH-1:0] res;

    assign s2_ready   = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s2_ready;
    // Data registers only load on a real transfer so idle X inputs never enter the pipe.
    assign s1_load    = in_ready && in_valid;
    assign s1_advance = s1_valid_q && s2_ready;

    always_comb begin
        res = '0;
        unique case (s1_op_q)
            3'b000: res = s1_x_q & s1_y_q;
            3'b001: res = s1_x_q | s1_y_q;
            3'b010: res = s1_x_q ^ s1_y_q;
            3'b011: res = ~(s1_x_q & s1_y_q);
            3'b100: res = ~(s1_x_q | s1_y_q);
            3'b101: res = ~(s1_x_q ^ s1_y_q);
            3'b110: res = ~s1_x_q;
            3'b111: res = s1_x_q;
            default: res = '0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (out_valid_q && out_ready) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_op_q    <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (s1_load) begin
                s1_x_q  <= x;
                s1_y_q  <= y;
                s1_op_q <= op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            count_q     <= '0;
        end else begin
            count_q <= count_d;
            if (s2_ready) begin
                out_valid_q <= s1_valid_q;
            end
            if (s1_advance) begin
                out_q <= res;
                zr_q  <= (res == '0);
                ng_q  <= res[WIDTH-1];
            end
        end
    end

    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: default 16/16 instance, a CNT_W=4 instance and a
// WIDTH=8 instance, all sharing clock and reset.
module tb_logic_unit_pipe;

    logic clk;
    logic rst;

    // Default instance
    logic [15:0] x, y, out;
    logic [2:0]  op;
    logic        in_valid, in_ready, zr, ng, out_valid, out_ready;
    logic [15:0] count;

    // CNT_W = 4 instance
    logic [15:0] c_x, c_y, c_out;
    logic [2:0]  c_op;
    logic        c_in_valid, c_in_ready, c_zr, c_ng, c_out_valid, c_out_ready;
    logic [3:0]  c_count;

    // WIDTH = 8 instance
    logic [7:0]  w_x, w_y, w_out;
    logic [2:0]  w_op;
    logic        w_in_valid, w_in_ready, w_zr, w_ng, w_out_valid, w_out_ready;
    logic [15:0] w_count;

    int checks;
    int failures;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] e_out;
        logic        e_zr;
        logic        e_ng;
    } vec_t;

    vec_t vecs[7];

    logic_unit_pipe #(.WIDTH(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .op(op), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .zr(zr), .ng(ng), .out_valid(out_valid),
        .out_ready(out_ready), .count(count)
    );

    logic_unit_pipe #(.WIDTH(16), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .x(c_x), .y(c_y), .op(c_op), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out(c_out), .zr(c_zr), .ng(c_ng), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .count(c_count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) u_w8 (
        .clk(clk), .rst(rst), .x(w_x), .y(w_y), .op(w_op), .in_valid(w_in_valid),
        .in_ready(w_in_ready), .out(w_out), .zr(w_zr), .ng(w_ng), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        op = o;
        x = a;
        y = b;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        op = 'x;
        x = 'x;
        y = 'x;
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        vecs[0] = '{3'b001, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0};
        vecs[1] = '{3'b011, 16'h0001, 16'h0001, 16'hFFFE, 1'b0, 1'b1};
        vecs[2] = '{3'b010, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{3'b110, 16'h0000, 16'h1234, 16'hFFFF, 1'b0, 1'b1};
        vecs[4] = '{3'b100, 16'h00FF, 16'h0F0F, 16'hF000, 1'b0, 1'b1};
        vecs[5] = '{3'b101, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b1};
        vecs[6] = '{3'b111, 16'h8000, 16'h7FFF, 16'h8000, 1'b0, 1'b1};

        rst = 1'b0;
        idle();
        out_ready = 1'b1;
        c_x = '0; c_y = '0; c_op = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
        w_x = '0; w_y = '0; w_op = '0; w_in_valid = 1'b0; w_out_ready = 1'b1;

        // Reset values
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_zr", 32'(zr), 32'd1);
        check("rst_ng", 32'(ng), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single AND, 2-cycle latency
        drive(3'b000, 16'h1263, 16'h2462);
        tick();
        idle();
        check("and_not_yet_valid", 32'(out_valid), 32'd0);
        tick();
        check("and_valid", 32'(out_valid), 32'd1);
        check("and_out", 32'(out), 32'h0062);
        check("and_zr", 32'(zr), 32'd0);
        check("and_ng", 32'(ng), 32'd0);
        tick();
        check("and_count", 32'(count), 32'd1);
        check("and_drained", 32'(out_valid), 32'd0);

        // Table: back-to-back vectors at full throughput
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) drive(vecs[i].op, vecs[i].x, vecs[i].y);
            else idle();
            tick();
            if (i >= 1) begin
                check($sformatf("vec%0d_valid", i - 1), 32'(out_valid), 32'd1);
                check($sformatf("vec%0d_out", i - 1), 32'(out), 32'(vecs[i - 1].e_out));
                check($sformatf("vec%0d_zr", i - 1), 32'(zr), 32'(vecs[i - 1].e_zr));
                check($sformatf("vec%0d_ng", i - 1), 32'(ng), 32'(vecs[i - 1].e_ng));
            end
        end
        tick();
        check("table_count", 32'(count), 32'd8);
        check("table_drained", 32'(out_valid), 32'd0);

        // Backpressure: A, B accepted, C blocked until out_ready rises
        out_ready = 1'b0;
        drive(3'b000, 16'hFFFF, 16'h00FF);
        tick();
        check("stall_ready_a", 32'(in_ready), 32'd1);
        drive(3'b001, 16'h0000, 16'h8000);
        tick();
        drive(3'b010, 16'hFFFF, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_hold", 32'(out), 32'h00FF);
            check("stall_valid_hold", 32'(out_valid), 32'd1);
            tick();
        end
        check("stall_count_hold", 32'(count), 32'd8);
        out_ready = 1'b1;
        #1;
        check("stall_ready_comb", 32'(in_ready), 32'd1);
        tick();
        idle();
        check("stall_b_out", 32'(out), 32'h8000);
        check("stall_b_ng", 32'(ng), 32'd1);
        check("stall_cnt9", 32'(count), 32'd9);
        tick();
        check("stall_c_out", 32'(out), 32'hFFFE);
        check("stall_c_valid", 32'(out_valid), 32'd1);
        check("stall_cnt10", 32'(count), 32'd10);
        tick();
        check("stall_drained", 32'(out_valid), 32'd0);
        check("stall_cnt11", 32'(count), 32'd11);

        // Asynchronous reset with two items in flight
        out_ready = 1'b0;
        drive(3'b111, 16'h4321, 16'h0000);
        tick();
        drive(3'b110, 16'h0F0F, 16'h0000);
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_out", 32'(out), 32'd0);
        check("arst_zr", 32'(zr), 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("arst_no_stale", 32'(out_valid), 32'd0);
        end

        // CNT_W = 4 wrap: 17 transfers at full rate
        for (int e = 0; e <= 18; e++) begin
            c_in_valid = (e < 17);
            c_op = 3'b111;
            c_x = 16'(e);
            tick();
            if (e >= 2) begin
                check($sformatf("c4_count_after_%0d", e - 1), 32'(c_count),
                      32'((e - 1) % 16));
            end
        end

        // WIDTH = 8 instance
        w_op = 3'b100; w_x = 8'h0F; w_y = 8'hF0; w_in_valid = 1'b1;
        tick();
        w_op = 3'b101; w_x = 8'h0F; w_y = 8'h00;
        tick();
        w_in_valid = 1'b0;
        check("w8_nor_out", 32'(w_out), 32'h00);
        check("w8_nor_zr", 32'(w_zr), 32'd1);
        tick();
        check("w8_xnor_out", 32'(w_out), 32'hF0);
        check("w8_xnor_ng", 32'(w_ng), 32'd1);
        check("w8_xnor_zr", 32'(w_zr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
